// File: rtl/cru_pkg.sv
// Shared types and elaboration-time helpers for the clock-enable/reset unit.
package cru_pkg;

    localparam int MAX_STAGES = 8;

    typedef int unsigned ratio_t;
    typedef ratio_t ratio_arr_t [MAX_STAGES];

    // Cumulative period of stage i (product of ratios 0..i), clamped at 2^32.
    function automatic longint unsigned stage_period(input ratio_arr_t r, input int i);
        longint unsigned p;
        p = 64'd1;
        for (int k = 0; k < MAX_STAGES; k++) begin
            if (k <= i) begin
                p = p * 64'(r[k]);
                if (p > 64'h1_0000_0000) begin
                    p = 64'h1_0000_0000;
                end
            end
        end
        return p;
    endfunction

    function automatic int cnt_width(input ratio_arr_t r, input int n);
        int unsigned mx;
        mx = 32'd1;
        for (int k = 0; k < MAX_STAGES; k++) begin
            if (k < n && r[k] > mx) begin
                mx = r[k];
            end
        end
        return (mx > 32'd1) ? $clog2(mx) : 1;
    endfunction

    function automatic bit cfg_ok(input ratio_arr_t r, input int n, input int unsigned hold);
        if (n < 1 || n > MAX_STAGES) begin
            return 1'b0;
        end
        for (int k = 0; k < MAX_STAGES; k++) begin
            if (k < n && r[k] < 32'd1) begin
                return 1'b0;
            end
        end
        if (stage_period(r, n - 1) > 64'h8000_0000) begin
            return 1'b0;
        end
        return (hold >= 32'd1);
    endfunction

endpackage

// File: rtl/cru_enable_unit_div_stage.sv
// One divider stage: phase counter, registered enable, reset-release hold
// counter and (when CRU_CLKOUT_EN is defined) a divided square-wave clock.
module cru_div_stage
    import cru_pkg::*;
#(
    parameter ratio_t      RATIO    = 2,
    parameter int          CW       = 1,
    parameter int unsigned RST_HOLD = 1
) (
    input  logic clk_s,
    input  logic reset_n,
    input  logic sync,
    input  logic in_en,
    output logic tc,
    output logic en,
    output logic clk_div,
    output logic reset_n_out,
    output logic reset_n_out_nxt
);

    localparam int HW = $clog2(RST_HOLD + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(RATIO - 1);
    localparam logic [HW-1:0] HC_LAST  = HW'(RST_HOLD - 1);

    logic [CW-1:0] cnt_d, cnt_q;
    logic [HW-1:0] hc_d, hc_q;
    logic          en_d, en_q;
    logic          rst_d, rst_q;

    // Next-state for phase counter, enable and reset-release sequencing.
    always_comb begin
        tc    = in_en && (cnt_q == CNT_LAST);
        cnt_d = cnt_q;
        hc_d  = hc_q;
        en_d  = 1'b0;
        rst_d = rst_q;
        if (!reset_n) begin
            cnt_d = '0;
            hc_d  = '0;
            rst_d = 1'b0;
        end else if (sync) begin
            cnt_d = '0;
        end else begin
            if (in_en) begin
                cnt_d = tc ? '0 : cnt_q + CW'(1);
            end else begin
                cnt_d = cnt_q;
            end
            en_d = tc;
            // Hold counter freezes once the domain has been released.
            if (tc && !rst_q) begin
                hc_d  = hc_q + HW'(1);
                rst_d = (hc_q == HC_LAST);
            end else begin
                hc_d  = hc_q;
            end
        end
    end

    // Stage state registers.
    always_ff @(posedge clk_s) begin
        cnt_q <= cnt_d;
        hc_q  <= hc_d;
        en_q  <= en_d;
        rst_q <= rst_d;
    end

    assign en              = en_q;
    assign reset_n_out     = rst_q;
    assign reset_n_out_nxt = rst_d;

`ifdef CRU_CLKOUT_EN
    localparam ratio_t        HALF     = (RATIO + 32'd1) / 32'd2;
    localparam logic [CW-1:0] CNT_HALF = CW'(HALF - 1);

    logic clk_div_d, clk_div_q;

    // Square wave: set with the enable, cleared at mid-period; set wins.
    always_comb begin
        clk_div_d = clk_div_q;
        if (!reset_n || sync) begin
            clk_div_d = 1'b0;
        end else if (tc) begin
            clk_div_d = 1'b1;
        end else if (in_en && (cnt_q == CNT_HALF)) begin
            clk_div_d = 1'b0;
        end else begin
            clk_div_d = clk_div_q;
        end
    end

    // Divided clock register.
    always_ff @(posedge clk_s) begin
        clk_div_q <= clk_div_d;
    end

    assign clk_div = clk_div_q;
`else
    assign clk_div = 1'b0;
`endif

endmodule

// File: rtl/cru_enable_unit.sv
// Cascaded clock-enable and sequenced reset unit; divided clock outputs are
// generated only when CRU_CLKOUT_EN is defined, otherwise tied low.
module cru_enable_unit
    import cru_pkg::*;
#(
    parameter int          NSTAGES  = 2,
    parameter ratio_arr_t  RATIO    = '{250, 30, 1, 1, 1, 1, 1, 1},
    parameter int unsigned RST_HOLD = 4
) (
    input  logic               clk_s,
    input  logic               reset_n,
    input  logic               sync,
    output logic [NSTAGES-1:0] en,
    output logic [NSTAGES-1:0] clk_div,
    output logic [NSTAGES-1:0] reset_n_out,
    output logic               locked
);

    localparam int CW = cnt_width(RATIO, NSTAGES);

    if (!cfg_ok(RATIO, NSTAGES, RST_HOLD)) begin : g_cfg_err
        $fatal(1, "cru_enable_unit: illegal NSTAGES/RATIO/RST_HOLD configuration");
    end

    logic [NSTAGES:0]   chain_s;
    logic [NSTAGES-1:0] rst_nxt_s;
    logic               unused_tc_s;
    logic               locked_d, locked_q;

    assign chain_s[0]  = 1'b1;
    assign unused_tc_s = chain_s[NSTAGES];

    for (genvar g = 0; g < NSTAGES; g++) begin : g_stage
        cru_div_stage #(
            .RATIO    (RATIO[g]),
            .CW       (CW),
            .RST_HOLD (RST_HOLD)
        ) u_stage (
            .clk_s           (clk_s),
            .reset_n         (reset_n),
            .sync            (sync),
            .in_en           (chain_s[g]),
            .tc              (chain_s[g+1]),
            .en              (en[g]),
            .clk_div         (clk_div[g]),
            .reset_n_out     (reset_n_out[g]),
            .reset_n_out_nxt (rst_nxt_s[g])
        );
    end

    // Lock tracks the next-state resets so it rises on the same edge.
    always_comb begin
        locked_d = reset_n && (&rst_nxt_s);
    end

    // Lock register.
    always_ff @(posedge clk_s) begin
        locked_q <= locked_d;
    end

    assign locked = locked_q;

endmodule

// File: tb/tb_cru_enable_unit.sv
// Randomized bench for cru_enable_unit: three configurations checked every
// cycle against an edge-count model, plus fixed expectations at key edges.
module tb_cru_enable_unit;
    import cru_pkg::*;

    localparam ratio_arr_t RA = '{250, 30, 1, 1, 1, 1, 1, 1};
    localparam ratio_arr_t RB = '{5, 3, 1, 1, 1, 1, 1, 1};
    localparam ratio_arr_t RC = '{1, 4, 1, 1, 1, 1, 1, 1};

    logic       clk_s = 1'b0;
    logic       rst_n_v [3];
    logic       sync_v  [3];
    logic [1:0] en_o    [3];
    logic [1:0] clk_o   [3];
    logic [1:0] rn_o    [3];
    logic       lk_o    [3];

    int total = 0;
    int bad   = 0;
    int k     = 0;

    int unsigned rat    [3][2];
    int unsigned per    [3][2];
    int          hold   [3];
    int          t      [3];
    int          pulses [3][2];

    always #5 clk_s = ~clk_s;

    cru_enable_unit #(.NSTAGES(2), .RATIO(RA), .RST_HOLD(4)) u_dut_a (
        .clk_s(clk_s), .reset_n(rst_n_v[0]), .sync(sync_v[0]),
        .en(en_o[0]), .clk_div(clk_o[0]), .reset_n_out(rn_o[0]), .locked(lk_o[0]));

    cru_enable_unit #(.NSTAGES(2), .RATIO(RB), .RST_HOLD(2)) u_dut_b (
        .clk_s(clk_s), .reset_n(rst_n_v[1]), .sync(sync_v[1]),
        .en(en_o[1]), .clk_div(clk_o[1]), .reset_n_out(rn_o[1]), .locked(lk_o[1]));

    cru_enable_unit #(.NSTAGES(2), .RATIO(RC), .RST_HOLD(3)) u_dut_c (
        .clk_s(clk_s), .reset_n(rst_n_v[2]), .sync(sync_v[2]),
        .en(en_o[2]), .clk_div(clk_o[2]), .reset_n_out(rn_o[2]), .locked(lk_o[2]));

    task automatic chk(input string nm, input int d, input logic [1:0] act, input logic [1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s dut%0d cycle %0d: got %b want %b", nm, d, k, act, exp);
        end
    endtask

    // Advance model d by one edge using the inputs applied at it, then compare.
    task automatic step_and_check(input int d);
        logic [1:0] e_en, e_rn, e_clk;
        int unsigned prev;
        if (!rst_n_v[d]) begin
            t[d] = 0;
            pulses[d][0] = 0;
            pulses[d][1] = 0;
        end else if (sync_v[d]) begin
            t[d] = 0;
        end else begin
            t[d]++;
            for (int i = 0; i < 2; i++) begin
                if ((t[d] % per[d][i]) == 0 && pulses[d][i] < hold[d]) pulses[d][i]++;
            end
        end
        for (int i = 0; i < 2; i++) begin
            e_en[i]  = (t[d] > 0) && ((t[d] % per[d][i]) == 0);
            e_rn[i]  = (pulses[d][i] >= hold[d]);
            e_clk[i] = 1'b0;
`ifdef CRU_CLKOUT_EN
            prev = (i == 0) ? 1 : per[d][i-1];
            e_clk[i] = (t[d] >= per[d][i]) &&
                       ((t[d] % per[d][i]) < ((rat[d][i] + 1) / 2) * prev);
`else
            prev = 0;
`endif
        end
        chk("en", d, en_o[d], e_en);
        chk("reset_n_out", d, rn_o[d], e_rn);
        chk("clk_div", d, clk_o[d], e_clk);
        chk("locked", d, {1'b0, lk_o[d]}, {1'b0, &e_rn});
    endtask

    initial begin
        int sync_k, rst_k, nend;
        rat[0][0] = 250; rat[0][1] = 30; hold[0] = 4;
        rat[1][0] = 5;   rat[1][1] = 3;  hold[1] = 2;
        rat[2][0] = 1;   rat[2][1] = 4;  hold[2] = 3;
        for (int d = 0; d < 3; d++) begin
            per[d][0] = rat[d][0];
            per[d][1] = rat[d][0] * rat[d][1];
            t[d] = 0;
            pulses[d][0] = 0;
            pulses[d][1] = 0;
        end
        sync_k = 30002 + 10000 + int'($urandom_range(0, 300));
        rst_k  = sync_k + 8000 + int'($urandom_range(0, 100));
        nend   = rst_k + 3 + 1100;

        for (k = 0; k < nend; k++) begin
            rst_n_v[0] = !(k < 3 || (k >= rst_k && k < rst_k + 3));
            sync_v[0]  = (k == sync_k);
            for (int d = 1; d < 3; d++) begin
                if (k < 3) begin
                    rst_n_v[d] = 1'b0;
                    sync_v[d]  = 1'b0;
                end else if (k < 200) begin
                    rst_n_v[d] = 1'b1;
                    sync_v[d]  = 1'b0;
                end else begin
                    rst_n_v[d] = ($urandom_range(0, 599) != 0);
                    sync_v[d]  = ($urandom_range(0, 79) == 0);
                end
            end
            @(posedge clk_s);
            #1;
            for (int d = 0; d < 3; d++) step_and_check(d);

            // Fixed expectations; edge 1 after the initial reset is k == 3.
            if (k == 2 + 249)   chk("a_en_before_250", 0, en_o[0], 2'b00);
            if (k == 2 + 250)   chk("a_en_at_250", 0, en_o[0], 2'b01);
            if (k == 2 + 7500)  chk("a_en_at_7500", 0, en_o[0], 2'b11);
            if (k == 2 + 999)   chk("a_rn_at_999", 0, rn_o[0], 2'b00);
            if (k == 2 + 1000)  chk("a_rn_at_1000", 0, rn_o[0], 2'b01);
            if (k == 2 + 29999) chk("a_lock_at_29999", 0, {1'b0, lk_o[0]}, 2'b00);
            if (k == 2 + 30000) chk("a_lock_at_30000", 0, {rn_o[0][1], lk_o[0]}, 2'b11);
            if (k == sync_k + 1)    chk("a_lock_after_sync", 0, {rn_o[0][0], lk_o[0]}, 2'b11);
            if (k == sync_k + 249)  chk("a_sync_en_249", 0, en_o[0], 2'b00);
            if (k == sync_k + 250)  chk("a_sync_en_250", 0, en_o[0], 2'b01);
            if (k == sync_k + 7500) chk("a_sync_en_7500", 0, en_o[0], 2'b11);
            if (k == rst_k)         chk("a_reset_rn", 0, rn_o[0], 2'b00);
            if (k == rst_k + 1)     chk("a_reset_en_lock", 0, {en_o[0][0], lk_o[0]}, 2'b00);
            if (k == rst_k + 2 + 1000) chk("a_rerun_rn_1000", 0, rn_o[0], 2'b01);
`ifdef CRU_CLKOUT_EN
            if (k == 2 + 15) chk("b_clk_at_15", 1, clk_o[1], 2'b11);
            if (k == 2 + 18) chk("b_clk_at_18", 1, clk_o[1], 2'b10);
`else
            if (k == 2 + 15) chk("b_clk_at_15", 1, clk_o[1], 2'b00);
            if (k == 2 + 18) chk("b_clk_at_18", 1, clk_o[1], 2'b00);
`endif
            if (k == 2 + 29) chk("b_rn_at_29", 1, rn_o[1], 2'b01);
            if (k == 2 + 30) chk("b_rn_at_30", 1, rn_o[1], 2'b11);
            if (k == 3)      chk("c_en_at_1", 2, en_o[2], 2'b01);
            if (k == 2 + 3)  chk("c_en_at_3", 2, en_o[2], 2'b01);
            if (k == 2 + 4)  chk("c_en_at_4", 2, en_o[2], 2'b11);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
